// File: rtl/bird_pkg.sv
// Shared definitions for the bird control FSM and its datapath:
// control state codes, redraw sequencer encoding and screen geometry.
package bird_pkg;

  localparam logic [2:0] B_START   = 3'b010;
  localparam logic [2:0] B_RAISING = 3'b110;
  localparam logic [2:0] B_FALLING = 3'b011;
  localparam logic [2:0] B_STOP    = 3'b001;
  localparam logic [2:0] B_DRAW    = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERASE = 3'd1,
    S_MOVE  = 3'd2,
    S_DRAW  = 3'd3,
    S_DONE  = 3'd4
  } seq_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

endpackage

// File: rtl/bird_datapath_sprite_raster.sv
// Steps a W x H pixel box one pixel per cycle from a latched origin;
// cx is the inner loop. Used for both erase and redraw passes.
module sprite_raster #(
  parameter int W = 4,
  parameter int H = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_start,
  input  logic [7:0] i_x0,
  input  logic [6:0] i_y0,
  input  logic [2:0] i_colour,
  output logic       o_plot,
  output logic [7:0] o_x,
  output logic [6:0] o_y,
  output logic [2:0] o_colour,
  output logic       o_last
);

  localparam int CXW = (W > 1) ? $clog2(W) : 1;
  localparam int CYW = (H > 1) ? $clog2(H) : 1;

  logic           r_plot;
  logic [CXW-1:0] r_cx;
  logic [CYW-1:0] r_cy;
  logic [7:0]     r_x0;
  logic [6:0]     r_y0;
  logic [2:0]     r_colour;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_plot   <= 1'b0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_colour <= '0;
    end else if (i_start) begin
      r_plot   <= 1'b1;
      r_cx     <= '0;
      r_cy     <= '0;
      r_x0     <= i_x0;
      r_y0     <= i_y0;
      r_colour <= i_colour;
    end else if (r_plot) begin
      if (r_cx == CXW'(W - 1)) begin
        r_cx <= '0;
        if (r_cy == CYW'(H - 1)) r_plot <= 1'b0;
        else                     r_cy   <= r_cy + 1'b1;
      end else begin
        r_cx <= r_cx + 1'b1;
      end
    end
  end

  assign o_plot   = r_plot;
  assign o_x      = r_x0 + 8'(r_cx);
  assign o_y      = r_y0 + 7'(r_cy);
  assign o_colour = r_colour;
  assign o_last   = r_plot && (r_cx == CXW'(W - 1)) && (r_cy == CYW'(H - 1));

endmodule

// File: rtl/bird_datapath.sv
// Bird position / rise counter datapath: per frame tick it erases the
// sprite, applies motion for the latched control state, and redraws it.
module bird_datapath
  import bird_pkg::*;
#(
  parameter int         X_POS       = 40,
  parameter int         BIRD_W      = 4,
  parameter int         BIRD_H      = 4,
  parameter int         START_Y     = 56,
  parameter int         TOP_Y       = 4,
  parameter int         GROUND_Y    = 112,
  parameter int         RISE_STEP   = 2,
  parameter int         FALL_STEP   = 1,
  parameter int         RISE_FRAMES = 6,
  parameter logic [2:0] BIRD_COL    = 3'b110,
  parameter logic [2:0] BG_COL      = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] i_state,
  input  logic       i_press_key,
  input  logic       i_pipe_hit,
  input  logic       i_frame_tick,
  output logic       o_flag,
  output logic       o_touched,
  output logic       o_plot,
  output logic [7:0] o_x,
  output logic [6:0] o_y,
  output logic [2:0] o_colour,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic [2:0] o_seq_state
);

  localparam int RCW = $clog2(RISE_FRAMES + 1);

  seq_t           r_seq;
  seq_t           w_seq_nxt;
  logic [2:0]     r_mstate;
  logic [6:0]     r_bird_y;
  logic [RCW-1:0] r_rise_cnt;
  logic           r_touched;
  logic           r_key_prev;

  logic [6:0] w_new_y;
  logic [7:0] w_y8;
  logic       w_ground_hit;
  logic       w_key_edge;
  logic       w_start;
  logic [6:0] w_org_y;
  logic [2:0] w_col;
  logic       w_last;
  logic       w_in_move;

  assign w_y8       = {1'b0, r_bird_y};
  assign w_key_edge = i_press_key & ~r_key_prev;
  assign w_in_move  = (r_seq == S_MOVE);

  // Motion is evaluated in 8 bits so saturation checks never wrap.
  always_comb begin
    w_new_y = r_bird_y;
    case (r_mstate)
      B_RAISING:
        if (w_y8 >= 8'(TOP_Y + RISE_STEP)) w_new_y = r_bird_y - 7'(RISE_STEP);
        else                                w_new_y = 7'(TOP_Y);
      B_FALLING:
        if (w_y8 + 8'(FALL_STEP) >= 8'(GROUND_Y - BIRD_H)) w_new_y = 7'(GROUND_Y - BIRD_H);
        else                                                 w_new_y = r_bird_y + 7'(FALL_STEP);
      B_START: w_new_y = 7'(START_Y);
      default: w_new_y = r_bird_y;
    endcase
  end

  assign w_ground_hit = ({1'b0, w_new_y} + 8'(BIRD_H)) >= 8'(GROUND_Y);

  always_comb begin
    w_seq_nxt = r_seq;
    w_start   = 1'b0;
    w_org_y   = r_bird_y;
    w_col     = BG_COL;
    case (r_seq)
      S_IDLE:
        if (i_frame_tick) begin
          w_seq_nxt = S_ERASE;
          w_start   = 1'b1;
        end
      S_ERASE: if (w_last) w_seq_nxt = S_MOVE;
      S_MOVE: begin
        // Redraw starts from the freshly computed position.
        w_seq_nxt = S_DRAW;
        w_start   = 1'b1;
        w_org_y   = w_new_y;
        w_col     = BIRD_COL;
      end
      S_DRAW:  if (w_last) w_seq_nxt = S_DONE;
      S_DONE:  w_seq_nxt = S_IDLE;
      default: w_seq_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_seq      <= S_IDLE;
      r_mstate   <= 3'b000;
      r_bird_y   <= 7'(START_Y);
      r_rise_cnt <= '0;
      r_touched  <= 1'b0;
      r_key_prev <= 1'b0;
    end else begin
      r_seq      <= w_seq_nxt;
      r_key_prev <= i_press_key;
      if (r_seq == S_IDLE && i_frame_tick) r_mstate <= i_state;
      if (w_in_move) r_bird_y <= w_new_y;

      if (w_key_edge && i_state != B_STOP)
        r_rise_cnt <= RCW'(RISE_FRAMES);
      else if (w_in_move && r_mstate == B_RAISING && r_rise_cnt != '0)
        r_rise_cnt <= r_rise_cnt - 1'b1;
      else if (w_in_move && r_mstate == B_START)
        r_rise_cnt <= '0;

      if (w_in_move && r_mstate == B_START)
        r_touched <= 1'b0;
      else if ((w_in_move && w_ground_hit) ||
               (i_pipe_hit && (r_mstate == B_RAISING || r_mstate == B_FALLING)))
        r_touched <= 1'b1;
    end
  end

  sprite_raster #(.W(BIRD_W), .H(BIRD_H)) u_raster (
    .clk      (clk),
    .resetn   (resetn),
    .i_start  (w_start),
    .i_x0     (8'(X_POS)),
    .i_y0     (w_org_y),
    .i_colour (w_col),
    .o_plot   (o_plot),
    .o_x      (o_x),
    .o_y      (o_y),
    .o_colour (o_colour),
    .o_last   (w_last)
  );

  assign o_flag       = (r_rise_cnt != '0) && (w_y8 > 8'(TOP_Y));
  assign o_touched    = r_touched;
  assign o_busy       = (r_seq == S_ERASE) || (r_seq == S_MOVE) || (r_seq == S_DRAW);
  assign o_frame_done = (r_seq == S_DONE);
  assign o_seq_state  = r_seq;

endmodule
